// File: rtl/mac_accum_if.sv
// mac_accum_if: product input and result output handshakes of the dot-product accumulator
interface mac_accum_if #(
  parameter int DATA_W = 8,
  parameter int K_LEN  = 8,
  parameter int ACC_W  = 2*DATA_W + $clog2(K_LEN) + 1
);
  logic                       prod_valid;
  logic                       prod_ready;
  logic [2*DATA_W-1:0]        prod_data;
  logic                       acc_clr;
  logic                       out_valid;
  logic                       out_ready;
  logic [ACC_W-1:0]           out_data;
  logic [$clog2(K_LEN+1)-1:0] term_cnt;
  modport master (
    output prod_valid, prod_data, acc_clr, out_ready,
    input  prod_ready, out_valid, out_data, term_cnt
  );
  modport slave (
    input  prod_valid, prod_data, acc_clr, out_ready,
    output prod_ready, out_valid, out_data, term_cnt
  );
endinterface

// File: rtl/mac_accum.sv
// mac_accum: sums K_LEN signed products into one dot product held in a one-entry output register
module mac_accum #(
  parameter int DATA_W = 8,
  parameter int K_LEN  = 8,
  parameter int ACC_W  = 2*DATA_W + $clog2(K_LEN) + 1
) (
  input logic        clk,
  input logic        rst,
  mac_accum_if.slave bus
);
  localparam int CW = $clog2(K_LEN+1);
  localparam logic [CW-1:0] LAST_CNT = CW'(K_LEN-1);
  typedef enum logic {ACCUM, LAST} state_t;
  state_t           state;
  logic [ACC_W-1:0] acc_q, acc_d, out_data_q, out_data_d, sum;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d, accept, final_acc, ready;
  always_comb begin
    state     = (cnt_q == LAST_CNT) ? LAST : ACCUM;
    ready     = !(state == LAST && out_valid_q && !bus.out_ready);
    accept    = bus.prod_valid && ready && !bus.acc_clr;
    final_acc = accept && state == LAST;
    sum       = acc_q + {{(ACC_W-2*DATA_W){bus.prod_data[2*DATA_W-1]}}, bus.prod_data};
    acc_d       = (bus.acc_clr || final_acc) ? '0 : accept ? sum : acc_q;
    cnt_d       = (bus.acc_clr || final_acc) ? '0 : accept ? cnt_q + CW'(1) : cnt_q;
    out_valid_d = final_acc || (out_valid_q && !bus.out_ready);
    out_data_d  = final_acc ? sum : out_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
  assign bus.prod_ready = ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.term_cnt   = cnt_q;
endmodule
